// File: rtl/alu_pkg.sv
// Shared ALU definitions: instruction-ID encodings, data width and the
// legality check used to decide whether an op goes through the ALU.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] ID_ADD  = 32'd1;
  localparam logic [DATA_W-1:0] ID_SUB  = 32'd2;
  localparam logic [DATA_W-1:0] ID_AND  = 32'd3;
  localparam logic [DATA_W-1:0] ID_OR   = 32'd4;
  localparam logic [DATA_W-1:0] ID_XOR  = 32'd5;
  localparam logic [DATA_W-1:0] ID_NOR  = 32'd6;
  localparam logic [DATA_W-1:0] ID_ADDI = 32'd7;
  localparam logic [DATA_W-1:0] ID_ANDI = 32'd8;
  localparam logic [DATA_W-1:0] ID_ORI  = 32'd9;
  localparam logic [DATA_W-1:0] ID_XORI = 32'd10;
  localparam logic [DATA_W-1:0] ID_SLL  = 32'd11;
  localparam logic [DATA_W-1:0] ID_SRL  = 32'd12;
  localparam logic [DATA_W-1:0] ID_SLT  = 32'd24;
  localparam logic [DATA_W-1:0] ID_SLTI = 32'd25;

  // One issued ALU operation as presented to alu_top.
  typedef struct packed {
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] id;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
  } alu_op_t;

  function automatic logic is_alu_op(input logic [DATA_W-1:0] id);
    return ((id >= ID_ADD) && (id <= ID_SRL)) || (id == ID_SLT) || (id == ID_SLTI);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester strictly after the
// last winner, wrapping; the pointer moves only when a grant is taken.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  i_req,
  input  logic             i_update,
  output logic [NREQ-1:0]  o_grant,
  output logic [IDX_W-1:0] o_grant_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_found;

  always_comb begin
    // NOTE: every output gets a default before the search loop so no path
    // leaves it unassigned, which would otherwise infer a latch.
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && i_req[(int'(r_ptr) + k) % NREQ]) begin
        w_found                              = 1'b1;
        o_grant[(int'(r_ptr) + k) % NREQ]    = 1'b1;
        o_grant_idx                          = IDX_W'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  // Reset to NREQ-1 so requester 0 is first in line after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= IDX_W'(NREQ - 1);
    end else if (i_update) begin
      // NOTE: state updates use <= so every flop samples pre-edge values.
      r_ptr <= o_grant_idx;
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one combinational ALU between NREQ requesters: round-robin issue
// register feeding alu_top, followed by a result register with backpressure.
module alu_issue_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_ir,
  input  logic [NREQ*32-1:0]   req_instr_id,
  input  logic [NREQ*32-1:0]   req_rs,
  input  logic [NREQ*32-1:0]   req_rt,
  output logic [31:0]          alu_ir,
  output logic [31:0]          alu_instr_id,
  output logic [31:0]          alu_rs,
  output logic [31:0]          alu_rt,
  input  logic [31:0]          alu_rd,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDX_W-1:0]     rsp_src,
  output logic [31:0]          rsp_rd,
  output logic                 rsp_err
);

  logic [NREQ-1:0]  w_grant;
  logic [IDX_W-1:0] w_grant_idx;
  logic             w_r_load;
  logic             w_i_load;
  logic             w_hs;
  alu_op_t          w_sel;

  alu_op_t          r_iss;
  logic             r_iss_v;
  logic [IDX_W-1:0] r_iss_src;
  logic             r_iss_err;

  logic             r_rsp_valid;
  logic [IDX_W-1:0] r_rsp_src;
  logic [31:0]      r_rsp_rd;
  logic             r_rsp_err;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (req_valid),
    .i_update    (w_hs),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign w_r_load = r_iss_v && (!r_rsp_valid || rsp_ready);
  assign w_i_load = !r_iss_v || w_r_load;
  // Gated by rst_n so no requester sees an accept while reset is held.
  assign req_ready = (rst_n && w_i_load) ? w_grant : '0;
  assign w_hs      = |(req_valid & req_ready);

  always_comb begin
    w_sel.ir = req_ir      [int'(w_grant_idx)*DATA_W +: DATA_W];
    w_sel.id = req_instr_id[int'(w_grant_idx)*DATA_W +: DATA_W];
    w_sel.rs = req_rs      [int'(w_grant_idx)*DATA_W +: DATA_W];
    w_sel.rt = req_rt      [int'(w_grant_idx)*DATA_W +: DATA_W];
  end

  // Operand regs only change on a handshake, so alu_* hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_v   <= 1'b0;
      r_iss     <= '0;
      r_iss_src <= '0;
      r_iss_err <= 1'b0;
    end else if (w_i_load) begin
      r_iss_v <= w_hs;
      if (w_hs) begin
        r_iss     <= w_sel;
        r_iss_src <= w_grant_idx;
        r_iss_err <= !is_alu_op(w_sel.id);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_src   <= '0;
      r_rsp_rd    <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_r_load) begin
      r_rsp_valid <= 1'b1;
      r_rsp_src   <= r_iss_src;
      r_rsp_rd    <= r_iss_err ? '0 : alu_rd;
      r_rsp_err   <= r_iss_err;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign alu_ir       = r_iss.ir;
  assign alu_instr_id = r_iss.id;
  assign alu_rs       = r_iss.rs;
  assign alu_rt       = r_iss.rt;

  assign rsp_valid = r_rsp_valid;
  assign rsp_src   = r_rsp_src;
  assign rsp_rd    = r_rsp_rd;
  assign rsp_err   = r_rsp_err;

endmodule
